if_pc_gen: RTL and testbench

//  Fetch-stage PC generator and prediction queue that sits directly upstream of btb.

---
 rtl/if_pc_gen.sv | 118 +++++++++++
 tb/tb_if_pc_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/if_pc_gen.sv
// Fetch-stage PC generator: drives btb lookups, folds predicted-taken targets into
// the next fetch with no bubble, and queues fetched PCs with predictions toward id.
module if_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_pc,
  output logic        fetch_en,
  input  logic        btb_ret_en,
  input  logic        btb_taken,
  input  logic [31:0] btb_ret_pc,
  input  logic [4:0]  btb_ret_index,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic        id_pred_taken,
  output logic [31:0] id_pred_target,
  output logic [4:0]  id_btb_index
);

  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LP_DEPTH = (CW+1)'(FQ_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [4:0]  index;
  } entry_t;

  logic [31:0]   r_pc;
  logic [31:0]   r_fetch_pc_q;
  logic          r_inflight;
  entry_t        r_mem [FQ_DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_hit;
  logic          w_resp_taken;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_occupancy;
  logic [31:0]   w_pc_plus4;
  entry_t        w_new;
  entry_t        w_head;

  assign w_hit        = r_inflight & btb_ret_en;
  assign w_resp_taken = w_hit & btb_taken;

  // Entries already queued plus the one whose btb response is pending form the credit.
  assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign fetch_en    = ~reset & (redirect_en | (w_occupancy < LP_DEPTH));

  always_comb begin
    fetch_pc = r_pc;
    if (redirect_en)
      fetch_pc = redirect_pc & ~32'h3;
    else if (w_resp_taken)
      fetch_pc = btb_ret_pc & ~32'h3;
  end

  assign w_pc_plus4 = fetch_pc + 32'd4;

  assign id_valid = (r_count != '0);
  assign w_push   = r_inflight & ~redirect_en;
  assign w_pop    = id_valid & id_ready & ~redirect_en;

  assign w_new.pc     = r_fetch_pc_q;
  assign w_new.taken  = w_resp_taken;
  assign w_new.target = w_hit ? btb_ret_pc : 32'd0;
  assign w_new.index  = w_hit ? btb_ret_index : 5'd0;

  assign w_head         = r_mem[r_head];
  assign id_pc          = id_valid ? w_head.pc     : 32'd0;
  assign id_pred_taken  = id_valid ? w_head.taken  : 1'b0;
  assign id_pred_target = id_valid ? w_head.target : 32'd0;
  assign id_btb_index   = id_valid ? w_head.index  : 5'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_fetch_pc_q <= 32'd0;
      r_inflight   <= 1'b0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
    end else begin
      r_inflight <= fetch_en;
      if (fetch_en)
        r_fetch_pc_q <= fetch_pc;
      // A stalled cycle keeps the selected PC so a taken target or redirect is not lost.
      r_pc <= fetch_en ? w_pc_plus4 : fetch_pc;
      if (redirect_en) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push)
          r_tail <= r_tail + AW'(1);
        if (w_pop)
          r_head <= r_head + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push)
      r_mem[r_tail] <= w_new;
  end

endmodule

// File: tb/tb_if_pc_gen.sv
// Bench for if_pc_gen: plays the btb, keeps a reference model of the fetch stream and
// a scoreboard of expected queue entries that is compared at the id interface.
module tb_if_pc_gen;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] fetch_pc;
  logic        fetch_en;
  logic        btb_ret_en = 1'b0;
  logic        btb_taken = 1'b0;
  logic [31:0] btb_ret_pc = 32'd0;
  logic [4:0]  btb_ret_index = 5'd0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic [4:0]  id_btb_index;

  if_pc_gen #(.RESET_PC(RESET_PC), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .fetch_pc(fetch_pc), .fetch_en(fetch_en),
    .btb_ret_en(btb_ret_en), .btb_taken(btb_taken),
    .btb_ret_pc(btb_ret_pc), .btb_ret_index(btb_ret_index),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .id_btb_index(id_btb_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [4:0]  index;
  } expEntry_t;

  expEntry_t   expQ[$];
  int          checks = 0;
  int          errors = 0;
  logic        modelKnown = 1'b0;
  logic        justReset = 1'b0;
  logic        mInflight = 1'b0;
  logic [31:0] mPc = 32'd0;
  logic [31:0] mFetchQ = 32'd0;
  logic        stallTaken = 1'b0;

  logic [31:0] hitPc     [3] = '{32'h1c000004, 32'h1c000104, 32'h1c000208};
  logic        hitTaken  [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] hitTarget [3] = '{32'h1c000100, 32'h1c000800, 32'h1c000300};
  logic [4:0]  hitIndex  [3] = '{5'd7, 5'd3, 5'd11};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void btbLookup(input logic [31:0] pc, output logic h, output logic t,
                                    output logic [31:0] tg, output logic [4:0] ix);
    h = 1'b0; t = 1'b0; tg = 32'd0; ix = 5'd0;
    for (int i = 0; i < 3; i++)
      if (hitPc[i] == pc) begin
        h = 1'b1; t = hitTaken[i]; tg = hitTarget[i]; ix = hitIndex[i];
      end
  endfunction

  // One cycle: drive at the falling edge, compare against the model, then advance the model.
  task automatic applyStimulus(input logic rst, input logic redir, input logic [31:0] rpc,
                               input logic rdy);
    logic        h, t, respTaken, expEn, pop;
    logic [31:0] tg, expPc;
    logic [4:0]  ix;
    @(negedge clk);
    if (mInflight) begin
      btbLookup(mFetchQ, h, t, tg, ix);
      if (stallTaken && expQ.size() == DEPTH - 1 && !rdy) begin
        h = 1'b1; t = 1'b1; tg = 32'h1c000500; ix = 5'd9;
      end
    end else begin
      h = 1'b1; t = 1'b1; tg = 32'hbad00000; ix = 5'd31;
    end
    reset = rst; redirect_en = redir; redirect_pc = rpc; id_ready = rdy;
    btb_ret_en = h; btb_taken = t; btb_ret_pc = tg; btb_ret_index = ix;
    #1;
    respTaken = mInflight & h & t;
    expPc = redir ? (rpc & ~32'h3) : (respTaken ? (tg & ~32'h3) : mPc);
    expEn = !rst && (redir || (expQ.size() + int'(mInflight) < DEPTH));
    if (modelKnown) begin
      checkOutput("fetch_en", fetch_en, expEn);
      if (!rst) checkOutput("fetch_pc", fetch_pc, expPc);
      checkOutput("id_valid", id_valid, expQ.size() != 0);
      if (expQ.size() != 0) begin
        checkOutput("id_pc", id_pc, expQ[0].pc);
        checkOutput("id_pred_taken", id_pred_taken, expQ[0].taken);
        checkOutput("id_pred_target", id_pred_target, expQ[0].target);
        checkOutput("id_btb_index", id_btb_index, expQ[0].index);
      end else if (justReset) begin
        checkOutput("rst_id_pc", id_pc, 32'd0);
        checkOutput("rst_id_pred_taken", id_pred_taken, 32'd0);
        checkOutput("rst_id_pred_target", id_pred_target, 32'd0);
        checkOutput("rst_id_btb_index", id_btb_index, 32'd0);
      end
    end
    if (rst) begin
      expQ.delete();
      mInflight = 1'b0; mPc = RESET_PC; modelKnown = 1'b1; justReset = 1'b1;
    end else if (modelKnown) begin
      justReset = 1'b0;
      pop = (expQ.size() != 0) && rdy && !redir;
      if (redir) expQ.delete();
      else begin
        if (pop) void'(expQ.pop_front());
        if (mInflight)
          expQ.push_back('{mFetchQ, respTaken, (mInflight & h) ? tg : 32'd0,
                           (mInflight & h) ? ix : 5'd0});
      end
      mInflight = expEn;
      if (expEn) mFetchQ = expPc;
      mPc = expEn ? expPc + 32'd4 : expPc;
    end
  endtask

  task automatic boundFail(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkOutput(tag, got, want);
  endtask

  initial begin
    int i;
    repeat (3) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);

    // Straight-line fetch, one taken hit (1c000004) and one not-taken hit (1c000104).
    repeat (12) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);

    // Stall: queue fills to depth, a taken response lands in the stall cycle.
    stallTaken = 1'b1;
    repeat (10) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    stallTaken = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("stall_target_fetch", fetch_pc, 32'h1c000500);
    repeat (4) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);

    // Redirect with three entries queued and a response in flight.
    for (i = 0; i < 20 && expQ.size() != 3; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    if (expQ.size() != 3) boundFail("reach_three_entries", expQ.size(), 3);
    applyStimulus(1'b0, 1'b1, 32'h1c000203, 1'b0);
    checkOutput("redirect_fetch_pc", fetch_pc, 32'h1c000200);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("redirect_flush_valid", id_valid, 32'd0);

    // Redirect colliding with a taken response for 1c000208.
    for (i = 0; i < 20 && !(mInflight && mFetchQ == 32'h1c000208); i++)
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    if (!(mInflight && mFetchQ == 32'h1c000208)) boundFail("reach_1c000208", mFetchQ, 32'h1c000208);
    applyStimulus(1'b0, 1'b1, 32'h1c000400, 1'b1);
    checkOutput("redirect_beats_taken", fetch_pc, 32'h1c000400);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);

    // Reset with a full queue, then restart from the reset PC.
    for (i = 0; i < 20 && expQ.size() != DEPTH; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    if (expQ.size() != DEPTH) boundFail("reach_full", expQ.size(), DEPTH);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("restart_fetch_pc", fetch_pc, RESET_PC);
    repeat (4) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);

    // Address wrap at the top of the 32-bit space.
    applyStimulus(1'b0, 1'b1, 32'hfffffffe, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("wrap_fetch_pc", fetch_pc, 32'd0);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);

    // Random ready and occasional redirects.
    for (int k = 0; k < 80; k++)
      applyStimulus(1'b0, ($urandom_range(0, 7) == 0), 32'h1c000000 | $urandom_range(0, 1023),
                    1'($urandom_range(0, 1)));
    repeat (8) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
